// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer: valid/ready pipeline-stage register with a 2-entry skid.
// in_ready is a flop, so there is no combinational path from out_ready back
// to in_ready. A synchronous flush empties the stage and loads NOP_VAL onto
// out_data.
// Optional feature macro: PIPE_SKID_STALL_CNT_EN adds a saturating 16-bit
// backpressure counter on stall_cnt. Without it, stall_cnt is tied to zero.
module pipe_skid_buffer #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [15:0]       stall_cnt
);

  // Occupancy: EMPTY (nothing held), ONE (main register only), TWO (main + skid).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e            state_q;
  logic              out_valid_q;
  logic              in_ready_q;
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] skid_data_q;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  // Occupancy FSM. It also drives the registered handshake outputs and the
  // two data registers.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_data_q  <= NOP_VAL;
      skid_data_q <= NOP_VAL;
    end else if (flush) begin
      // Any input offered in this cycle is dropped. A completing output
      // transfer needs no action here.
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_data_q  <= NOP_VAL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            out_data_q  <= in_data;
            out_valid_q <= 1'b1;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            out_data_q <= in_data;
          end else if (in_xfer) begin
            skid_data_q <= in_data;
            in_ready_q  <= 1'b0;
            state_q     <= TWO;
          end else if (out_xfer) begin
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so the only possible event is a drain.
          if (out_xfer) begin
            out_data_q <= skid_data_q;
            in_ready_q <= 1'b1;
            state_q    <= ONE;
          end
        end
        default: begin
          state_q     <= EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef PIPE_SKID_STALL_CNT_EN
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;

  // Saturating count of cycles that hold a valid output while downstream is
  // not ready.
  // NOTE: the default assignment first keeps this combinational block from
  // inferring a latch.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register. Only reset clears it; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Self-checking bench for pipe_skid_buffer. The reference model is a bounded
// queue of at most two payloads. Build with or without PIPE_SKID_STALL_CNT_EN.
module tb_pipe_skid_buffer;

  localparam int          DATA_W = 32;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] stall_cnt;

  pipe_skid_buffer #(
    .DATA_W (DATA_W),
    .NOP_VAL(NOP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queued payloads in FIFO order and a saturating stall count.
  logic [31:0] mq[$];
  bit          nop_known = 1'b0;
  int          m_stall   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic compare_model();
    check("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
    check("in_ready",  {31'd0, in_ready},  {31'd0, mq.size() < 2});
    if (mq.size() > 0)
      check("out_data", out_data, mq[0]);
    else if (nop_known)
      check("out_data_nop", out_data, NOP);
    check("stall_cnt", {16'd0, stall_cnt}, m_stall);
  endtask

  // One clock cycle: drive the inputs and confirm that toggling out_ready does
  // not move in_ready. Then take the edge, advance the model and compare.
  task automatic cycle(input bit r, input bit f, input bit iv,
                       input logic [31:0] id, input bit ordy);
    logic ir_before;
    bit   ix;
    bit   ox;
    rst_n = r; flush = f; in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    ir_before = in_ready;
    out_ready = ~ordy;
    #1;
    check("in_ready_comb", {31'd0, in_ready}, {31'd0, ir_before});
    out_ready = ordy;
    @(posedge clk);
    ix = iv && (mq.size() < 2);
    ox = ordy && (mq.size() > 0);
    if (!r) begin
      mq.delete();
      nop_known = 1'b1;
      m_stall   = 0;
    end else begin
`ifdef PIPE_SKID_STALL_CNT_EN
      if ((mq.size() > 0) && !ordy && (m_stall < 65535)) m_stall++;
`endif
      if (f) begin
        mq.delete();
        nop_known = 1'b1;
      end else begin
        if (ox) void'(mq.pop_front());
        if (ix) begin
          mq.push_back(id);
          nop_known = 1'b0;
        end
      end
    end
    #1;
    compare_model();
  endtask

  initial begin
    // Reset, with an input offered during reset that must be ignored.
    cycle(0, 0, 1, 32'hDEADBEEF, 1);
    cycle(0, 0, 1, 32'hDEADBEEF, 1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  out_data, NOP);
    check("rst_in_ready",  {31'd0, in_ready}, 32'd1);

    // Throughput: stream 1..8 with out_ready held high.
    for (int i = 1; i <= 8; i++) cycle(1, 0, 1, i, 1);
    check("stream_last", out_data, 32'd8);
    cycle(1, 0, 0, 32'h0, 1);
    check("stream_drained", {31'd0, out_valid}, 32'd0);

    // Backpressure: A then B with out_ready low.
    cycle(1, 0, 1, 32'hA, 0);
    cycle(1, 0, 1, 32'hB, 0);
    check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_out_data", out_data, 32'hA);
    cycle(1, 0, 0, 32'h0, 1);
    check("bp_second", out_data, 32'hB);
    check("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    cycle(1, 0, 0, 32'h0, 1);

    // Flush while holding two entries: C is offered and must be dropped.
    cycle(1, 0, 1, 32'hA, 0);
    cycle(1, 0, 1, 32'hB, 0);
    cycle(1, 1, 1, 32'hC, 0);
    check("fl_out_valid", {31'd0, out_valid}, 32'd0);
    check("fl_out_data",  out_data, NOP);
    check("fl_in_ready",  {31'd0, in_ready}, 32'd1);
    cycle(1, 1, 1, 32'hC, 1);
    check("fl_twice", {31'd0, out_valid}, 32'd0);

    // Reset has priority over flush and over the offered input in state ONE.
    cycle(1, 0, 1, 32'h55, 0);
    cycle(0, 1, 1, 32'h66, 1);
    check("rp_out_valid", {31'd0, out_valid}, 32'd0);
    check("rp_out_data",  out_data, NOP);
    check("rp_stall",     {16'd0, stall_cnt}, 32'd0);

    // Stall counter: one held entry and 5 stalled cycles.
    cycle(1, 0, 1, 32'h77, 0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 32'h0, 0);
`ifdef PIPE_SKID_STALL_CNT_EN
    check("stall_5", {16'd0, stall_cnt}, 32'd5);
`else
    check("stall_off", {16'd0, stall_cnt}, 32'd0);
`endif
    cycle(1, 1, 0, 32'h0, 1);
`ifdef PIPE_SKID_STALL_CNT_EN
    check("stall_keep_flush", {16'd0, stall_cnt}, 32'd5);
    cycle(1, 0, 1, 32'h88, 0);
    for (int i = 0; i < 65540; i++) cycle(1, 0, 0, 32'h0, 0);
    check("stall_sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
`else
    check("stall_off_flush", {16'd0, stall_cnt}, 32'd0);
`endif

    // Random traffic with about 1% flush, checked against the model every cycle.
    for (int i = 0; i < 10000; i++) begin
      cycle(1, ($urandom_range(99) == 0), ($urandom_range(99) < 65), $urandom,
            ($urandom_range(99) < 60));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
